decoder_nx2n_seq: RTL

Parametrised registered N-to-2^N one-hot decoder with valid/ready handshakes on input and output. It adds a scan mode that walks the one-hot output through consecutive codes with modulo wrap, for row/column strobing and channel sequencing. It sits between a command source and strobe/select consumers (LED matrices, mux selects, chip selects) that apply backpressure.

---
 rtl/decoder_nx2n_seq.sv | 109 ++++++++++
 1 files changed

// File: rtl/decoder_nx2n_seq.sv
// Registered N-to-2^N one-hot decoder with valid/ready on both sides and a
// scan mode that walks the one-hot through consecutive codes with wrap.
module decoder_nx2n_seq #(
    parameter int N          = 3,
    parameter bit ACTIVE_LOW = 1'b0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [N-1:0]        in_code,
    input  logic                in_mode,
    input  logic [N-1:0]        in_len,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [(1<<N)-1:0]   out,
    output logic                busy,
    output logic [1:0]          state_dbg
);

    localparam int W = 1 << N;
    localparam logic [W-1:0] INACTIVE = {W{ACTIVE_LOW}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        SCAN = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   onehot_q, onehot_d;
    logic [N-1:0]   remaining_q, remaining_d;
    logic           accept;
    logic           consume;
    logic           load;

    // Handshake: a transfer happens on a rising edge where valid && ready.
    // Sources hold valid and payload stable until the transfer; in_ready is
    // a function of state and out_ready only, never of in_valid.
    always_comb begin
        in_ready = 1'b0;
        case (state_q)
            IDLE:    in_ready = rst_n;
            HOLD:    in_ready = rst_n && out_ready;
            default: in_ready = 1'b0;
        endcase
    end

    assign out_valid = (state_q == HOLD) || (state_q == SCAN);
    assign accept    = in_valid && in_ready;
    assign consume   = out_valid && out_ready;

    always_comb begin
        state_d     = state_q;
        onehot_d    = onehot_q;
        remaining_d = remaining_q;
        load        = 1'b0;
        case (state_q)
            IDLE: begin
                load = accept;
            end
            HOLD: begin
                if (consume) begin
                    if (accept) load = 1'b1;
                    else        state_d = IDLE;
                end
            end
            SCAN: begin
                if (consume) begin
                    if (remaining_q == '0) begin
                        state_d = IDLE;
                    end else begin
                        // Rotate left: code advances by one modulo 2^N.
                        onehot_d    = {onehot_q[W-2:0], onehot_q[W-1]};
                        remaining_d = remaining_q - 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (load) begin
            onehot_d    = W'(1) << in_code;
            state_d     = in_mode ? SCAN : HOLD;
            remaining_d = in_mode ? in_len : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            onehot_q    <= '0;
            remaining_q <= '0;
        end else begin
            state_q     <= state_d;
            onehot_q    <= onehot_d;
            remaining_q <= remaining_d;
        end
    end

    // Enable and polarity are applied after the register so en never stalls
    // or advances the sequence.
    assign out       = (en && out_valid) ? (ACTIVE_LOW ? ~onehot_q : onehot_q) : INACTIVE;
    assign busy      = (state_q == SCAN);
    assign state_dbg = state_q;

endmodule
